score_display: RTL and testbench

Scoreboard driver for the handball/ping-pong game. Consumes the two 4-bit score buses the game core drives (Score_Left, Score_Right, binary 0–15) and time-multiplexes them onto a 4-digit common-anode 7-segment display as two 2-digit decimal numbers. On any score change, it optionally blinks the changed side's digits for a fixed period. The block sits between the game core outputs and the board's segment/anode pins.

---
 rtl/score_display.sv | 155 +++++++++++++++
 tb/tb_score_display.sv | 124 ++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: drives a 4-digit common-anode 7-segment display with two 0-15 scores
//
// Shows the right score on digits 0/1 and the left score on digits 2/3 as
// two-digit decimal numbers. A zero tens digit is blanked. The decimal point
// on the left units digit separates the two scores.
//
// Optional feature (compile-time macro SCORE_FLASH_EN): after a score
// changes, that side's digits blink for FLASH_CYCLES cycles. The blank
// phase is selected by bit BLINK_BIT of the flash down-counter.
//
// Parameters:
//   SCAN_DIV     - clk_game cycles per digit slot (>= 2)
//   FLASH_CYCLES - blink duration after a score change (>= 2)
//   BLINK_BIT    - flash counter bit that selects the blank phase
// Ports:
//   clk_game    - single clock for all state
//   rst         - synchronous reset, active low
//   Score_Left  - left score, binary 0-15
//   Score_Right - right score, binary 0-15
//   Seg         - segments {g,f,e,d,c,b,a}, active low, registered
//   Dp          - decimal point, active low, registered
//   An          - digit anodes, active low, one-hot-low when driving, registered
module score_display #(
    parameter int SCAN_DIV     = 1024,
    parameter int FLASH_CYCLES = 65536,
    parameter int BLINK_BIT    = 13
) (
    input  logic       clk_game,
    input  logic       rst,
    input  logic [3:0] Score_Left,
    input  logic [3:0] Score_Right,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = ($clog2(FLASH_CYCLES) > BLINK_BIT) ? $clog2(FLASH_CYCLES) : BLINK_BIT + 1;

    if (SCAN_DIV < 2 || FLASH_CYCLES < 2 || BLINK_BIT >= FW) begin : g_bad_cfg
        $error("score_display: illegal parameter combination");
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Side index 0 is the right score, 1 is the left score, so digit_idx[1]
    // selects the side directly.
    logic [1:0][3:0] s_q, s_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]      digit_idx_q, digit_idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [1:0]      blank;
    logic            wrap;
    logic [3:0]      side_s;
    logic            ge10;
    logic [3:0]      units;
    logic [6:0]      digit_seg;

    assign s_d  = {Score_Left, Score_Right};
    assign wrap = scan_cnt_q == SW'(SCAN_DIV - 1);

`ifdef SCORE_FLASH_EN
    typedef enum logic {IDLE, FLASH} flash_state_t;

    flash_state_t    state_q [2];
    flash_state_t    state_d [2];
    logic [1:0][FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [1:0][3:0] prev_q;

    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        blank       = 2'b00;
        for (int i = 0; i < 2; i++) begin
            blank[i] = (state_q[i] == FLASH) && flash_cnt_q[i][BLINK_BIT];
            // A change always (re)starts the blink, even mid-flash.
            if (s_q[i] != prev_q[i]) begin
                state_d[i]     = FLASH;
                flash_cnt_d[i] = FW'(FLASH_CYCLES - 1);
            end else if (state_q[i] == FLASH) begin
                if (flash_cnt_q[i] == '0)
                    state_d[i] = IDLE;
                else
                    flash_cnt_d[i] = flash_cnt_q[i] - FW'(1);
            end
        end
    end

    always_ff @(posedge clk_game) begin
        if (!rst) begin
            state_q[0]  <= IDLE;
            state_q[1]  <= IDLE;
            flash_cnt_q <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            prev_q      <= s_q;
        end
    end
`else
    assign blank = 2'b00;
`endif

    always_comb begin
        scan_cnt_d  = wrap ? '0 : scan_cnt_q + SW'(1);
        digit_idx_d = digit_idx_q + {1'b0, wrap};
        // Scores never exceed 15, so one compare replaces a divide by ten.
        side_s      = s_q[digit_idx_q[1]];
        ge10        = side_s >= 4'd10;
        units       = ge10 ? side_s - 4'd10 : side_s;
        digit_seg   = digit_idx_q[0] ? (ge10 ? seg_code(4'd1) : 7'b1111111) : seg_code(units);
        // The slot's last cycle is dark so the anode switch cannot ghost.
        an_d        = wrap ? 4'b1111 : ~(4'b0001 << digit_idx_q);
        seg_d       = (wrap || blank[digit_idx_q[1]]) ? 7'b1111111 : digit_seg;
        dp_d        = wrap || (digit_idx_q != 2'd2);
    end

    always_ff @(posedge clk_game) begin
        if (!rst) begin
            s_q         <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            s_q         <= s_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign An  = an_q;
    assign Seg = seg_q;
    assign Dp  = dp_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display
module tb_score_display;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
`ifdef SCORE_FLASH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic       clk_game = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Score_Left = 4'd0;
    logic [3:0] Score_Right = 4'd0;
    logic [6:0] Seg;
    logic       Dp;
    logic [3:0] An;
    int         checks = 0;
    int         errors = 0;
    int         k = 0;

    always #5 clk_game = ~clk_game;

    score_display #(.SCAN_DIV(4), .FLASH_CYCLES(16), .BLINK_BIT(2)) dut (
        .clk_game(clk_game),
        .rst(rst),
        .Score_Left(Score_Left),
        .Score_Right(Score_Right),
        .Seg(Seg),
        .Dp(Dp),
        .An(An)
    );

    task automatic tick();
        @(posedge clk_game);
        #1;
        k++;
    endtask

    task automatic to_k(input int t);
        while (k < t) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        checks++;
        assert ({An, Seg, Dp} === {a, s, d}) else begin
            errors++;
            $error("FAIL %s k=%0d: An/Seg/Dp got %b/%b/%b expected %b/%b/%b", tag, k, An, Seg, Dp, a, s, d);
        end
    endtask

    logic [3:0] an_tab  [16] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111,
                                 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b1111};
    logic [6:0] seg_tab [16] = '{S0, S0, S0, BL, BL, BL, BL, BL, S0, S0, S0, BL, BL, BL, BL, BL};
    logic       dp_tab  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        repeat (2) @(posedge clk_game);
        #1;
        chk("reset", 4'b1111, BL, 1'b1);
        rst = 1'b1;
        k = 0;
        // First frame with both scores zero: idx0 first, full scan order.
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("frame0", an_tab[i], seg_tab[i], dp_tab[i]);
        end
        tick();
        chk("frame_wrap", 4'b1110, S0, 1'b1);
        // Left 12, right 7; checked once any blink has long finished.
        to_k(16);
        Score_Left  = 4'd12;
        Score_Right = 4'd7;
        to_k(49); chk("r_units7", 4'b1110, S7, 1'b1);
        to_k(52); chk("dark", 4'b1111, BL, 1'b1);
        to_k(53); chk("r_tens_blank", 4'b1101, BL, 1'b1);
        to_k(57); chk("l_units2", 4'b1011, S2, 1'b0);
        to_k(61); chk("l_tens1", 4'b0111, S1, 1'b1);
        to_k(64); chk("dark2", 4'b1111, BL, 1'b1);
        Score_Right = 4'd3;
        to_k(97); chk("r_units3", 4'b1110, S3, 1'b1);
        // Right 3 -> 4: blank while counter is 15..12 and 7..4.
        to_k(107);
        Score_Right = 4'd4;
        to_k(113); chk("flash_blank", 4'b1110, FL ? BL : S4, 1'b1);
        to_k(114); chk("flash_lit", 4'b1110, S4, 1'b1);
        to_k(121); chk("left_unblanked", 4'b1011, S2, 1'b0);
        to_k(129); chk("flash_done", 4'b1110, S4, 1'b1);
        // Both sides change together, left changes again 5 cycles later.
        to_k(141);
        Score_Left  = 4'd15;
        Score_Right = 4'd13;
        to_k(145); chk("both_r_blank", 4'b1110, FL ? BL : S3, 1'b1);
        to_k(146);
        Score_Left = 4'd10;
        to_k(149); chk("both_r_tens_lit", 4'b1101, S1, 1'b1);
        to_k(153); chk("both_l_units_lit", 4'b1011, S0, 1'b0);
        to_k(157); chk("left_reload_blank", 4'b0111, FL ? BL : S1, 1'b1);
        to_k(161); chk("right_ended", 4'b1110, S3, 1'b1);
        to_k(169); chk("left_ended", 4'b1011, S0, 1'b0);
        // Reset mid-slot and mid-flash.
        to_k(170);
        Score_Right = 4'd5;
        to_k(174);
        rst = 1'b0;
        Score_Left  = 4'd0;
        Score_Right = 4'd0;
        tick();
        chk("rst_mid", 4'b1111, BL, 1'b1);
        rst = 1'b1;
        k = 0;
        tick(); chk("restart_idx0", 4'b1110, S0, 1'b1);
        to_k(3); chk("restart_no_flash", 4'b1110, S0, 1'b1);
        to_k(4); chk("restart_dark", 4'b1111, BL, 1'b1);
        to_k(9); chk("restart_idx2", 4'b1011, S0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
